// File: rtl/pm_pkg.sv
// Shared definitions for the power-gating wake-up scheduler.
//   pm_state_e : per-port wake-up FSM encoding
//   CNT_W      : width of the per-port wake-up latency counter
package pm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PEND = 2'b01,
        WAKE = 2'b10
    } pm_state_e;

    localparam int unsigned CNT_W = 8;

endpackage : pm_pkg

// File: rtl/wake_rr_arbiter.sv
// Single-grant arbiter for wake-up slots.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   req        : per-port request vector (ports pending with a valid request)
//   enable     : a slot is free this cycle; no grant is issued when low
//   grant      : one-hot grant (combinational), all zero when nothing is granted
// Macro WAKE_RR_EN: round-robin search starting after the last granted port.
// Without it the search pointer stays at port 0, giving fixed priority with the
// lowest index winning.
module wake_rr_arbiter #(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 enable,
    output logic [NUM_PORTS-1:0] grant
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

`ifdef WAKE_RR_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic             found;

    // Circular search from ptr; first requesting port wins.
    always_comb begin
        int unsigned idx;
        grant   = '0;
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
        if (enable && found) begin
            grant[win_idx] = 1'b1;
        end
    end

    // Pointer moves past the winner only in round-robin builds.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (ROUND_ROBIN && enable && found) begin
            ptr <= (32'(win_idx) == NUM_PORTS - 1) ? '0 : win_idx + IDX_W'(1);
        end
    end

endmodule : wake_rr_arbiter

// File: rtl/pg_wakeup_scheduler.sv
// Inrush-limited wake-up scheduler for power-gated router ports.
// Each port runs an IDLE/PEND/WAKE FSM; at most MAX_ACTIVE ports hold a
// wake-up slot at once, each for WAKE_UP_LATENCY cycles (1..255).
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   wake_req     : per-port level request to power the router back on
//   pwr_gated    : per-port status, high while the router is gated
//   wake_grant   : one-cycle pulse in the cycle a port is granted
//   waking       : high while the port holds a wake-up slot
//   wake_done    : one-cycle pulse after the slot is released
//   active_count : number of ports currently waking
// Macro WAKE_RR_EN: round-robin arbitration (default: fixed priority, port 0 highest).
module pg_wakeup_scheduler
    import pm_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned MAX_ACTIVE      = 2,
    parameter int unsigned WAKE_UP_LATENCY = 200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] wake_req,
    input  logic [NUM_PORTS-1:0] pwr_gated,
    output logic [NUM_PORTS-1:0] wake_grant,
    output logic [NUM_PORTS-1:0] waking,
    output logic [NUM_PORTS-1:0] wake_done,
    output logic [7:0]           active_count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAKE_UP_LATENCY - 1);

    pm_state_e            state [NUM_PORTS];
    logic [CNT_W-1:0]     cnt   [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_valid;
    logic [NUM_PORTS-1:0] arb_req;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] waking_nxt;
    logic [7:0]           count_nxt;
    logic                 arb_en;

    // A request is only meaningful while the router is actually gated.
    always_comb begin
        req_valid = '0;
        arb_req   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_valid[i] = wake_req[i] & pwr_gated[i];
            arb_req[i]   = (state[i] == PEND) & req_valid[i];
        end
    end

    // active_count is registered, so a slot freed at an edge is visible next cycle.
    assign arb_en = !reset && (active_count < 8'(MAX_ACTIVE));

    wake_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (arb_req),
        .enable (arb_en),
        .grant  (grant)
    );

    assign wake_grant = grant;

    // Slot occupancy after the coming edge; feeds waking and active_count.
    always_comb begin
        waking_nxt = '0;
        count_nxt  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            case (state[i])
                PEND:    waking_nxt[i] = grant[i];
                WAKE:    waking_nxt[i] = (cnt[i] != LAST_CNT);
                default: waking_nxt[i] = 1'b0;
            endcase
            count_nxt = count_nxt + 8'(waking_nxt[i]);
        end
    end

    // Per-port FSMs with registered waking/wake_done/active_count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            waking       <= '0;
            wake_done    <= '0;
            active_count <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wake_done[i] <= 1'b0;
                case (state[i])
                    IDLE: begin
                        if (req_valid[i]) begin
                            state[i] <= PEND;
                        end
                    end
                    PEND: begin
                        if (grant[i]) begin
                            state[i] <= WAKE;
                            cnt[i]   <= '0;
                        end else if (!req_valid[i]) begin
                            state[i] <= IDLE;
                        end
                    end
                    WAKE: begin
                        // Inputs are ignored until the slot is released.
                        if (cnt[i] == LAST_CNT) begin
                            state[i]     <= IDLE;
                            cnt[i]       <= '0;
                            wake_done[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                    end
                endcase
            end
            waking       <= waking_nxt;
            active_count <= count_nxt;
        end
    end

endmodule : pg_wakeup_scheduler

// File: tb/tb_pg_wakeup_scheduler.sv
// Randomized and directed bench for pg_wakeup_scheduler with a
// timestamp-based reference model and a queue-driven output monitor.
module tb_pg_wakeup_scheduler;

    localparam int unsigned N    = 4;
    localparam int unsigned MAXA = 2;
    localparam int unsigned LAT  = 200;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] wake_req = '0;
    logic [N-1:0] pwr_gated = '0;
    logic [N-1:0] wake_grant;
    logic [N-1:0] waking;
    logic [N-1:0] wake_done;
    logic [7:0]   active_count;

    always #5 clk = ~clk;

    pg_wakeup_scheduler #(
        .NUM_PORTS       (N),
        .MAX_ACTIVE      (MAXA),
        .WAKE_UP_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wake_req     (wake_req),
        .pwr_gated    (pwr_gated),
        .wake_grant   (wake_grant),
        .waking       (waking),
        .wake_done    (wake_done),
        .active_count (active_count)
    );

    typedef struct packed {
        logic [N-1:0] grant;
        logic [N-1:0] waking;
        logic [N-1:0] done;
        logic [7:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: 0 = idle, 1 = pending, 2 = holding a slot.
    int m_st    [N];
    int m_start [N];
    bit m_done  [N];
    int m_ptr = 0;
    int cyc   = 0;

    initial begin
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_start[i] = 0; m_done[i] = 1'b0;
        end
    end

    // Predict this cycle's outputs from the applied inputs, then advance one edge.
    function automatic void model_cycle();
        exp_t e;
        int   active;
        int   winner;
        int   p;
        bit   v;
        e = '0;
        active = 0;
        winner = -1;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 2) begin
                e.waking[i] = 1'b1;
                active++;
            end
            e.done[i] = m_done[i];
        end
        e.cnt = 8'(active);
        if (!reset && active < int'(MAXA)) begin
            for (int k = 0; k < N; k++) begin
                p = (m_ptr + k) % N;
                if (winner < 0 && m_st[p] == 1 && wake_req[p] && pwr_gated[p]) winner = p;
            end
        end
        if (winner >= 0) e.grant[winner] = 1'b1;
        exp_q.push_back(e);

        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_st[i] = 0; m_done[i] = 1'b0;
            end
            m_ptr = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                v = wake_req[i] && pwr_gated[i];
                m_done[i] = 1'b0;
                if (m_st[i] == 2) begin
                    if (cyc - m_start[i] == int'(LAT) - 1) begin
                        m_st[i] = 0;
                        m_done[i] = 1'b1;
                    end
                end else if (m_st[i] == 1) begin
                    if (i == winner) begin
                        m_st[i] = 2;
                        m_start[i] = cyc + 1;
                    end else if (!v) begin
                        m_st[i] = 0;
                    end
                end else if (v) begin
                    m_st[i] = 1;
                end
            end
`ifdef WAKE_RR_EN
            if (winner >= 0) m_ptr = (winner + 1) % N;
`endif
        end
        cyc++;
    endfunction

    task automatic step(input logic rst, input logic [N-1:0] rq, input logic [N-1:0] pg);
        @(posedge clk);
        #1;
        reset     = rst;
        wake_req  = rq;
        pwr_gated = pg;
        model_cycle();
    endtask

    task automatic hold(input int n, input logic rst, input logic [N-1:0] rq, input logic [N-1:0] pg);
        for (int c = 0; c < n; c++) step(rst, rq, pg);
    endtask

    // Monitor: compare DUT outputs against the oldest prediction each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (wake_grant !== e.grant) begin
                errors++;
                $display("FAIL wake_grant cyc=%0d got=%b exp=%b", cyc, wake_grant, e.grant);
            end
            checks++;
            if (waking !== e.waking) begin
                errors++;
                $display("FAIL waking cyc=%0d got=%b exp=%b", cyc, waking, e.waking);
            end
            checks++;
            if (wake_done !== e.done) begin
                errors++;
                $display("FAIL wake_done cyc=%0d got=%b exp=%b", cyc, wake_done, e.done);
            end
            checks++;
            if (active_count !== e.cnt) begin
                errors++;
                $display("FAIL active_count cyc=%0d got=%0d exp=%0d", cyc, active_count, e.cnt);
            end
            checks++;
            if (!(active_count <= 8'(MAXA))) begin
                errors++;
                $display("FAIL inrush_limit cyc=%0d got=%0d max=%0d", cyc, active_count, MAXA);
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        logic [N-1:0] pg;

        hold(3, 1'b1, '0, '0);

        // Single request on port 1, request dropped once granted.
        hold(2, 1'b0, 4'b0010, 4'b0010);
        hold(205, 1'b0, 4'b0000, 4'b0010);

        // All ports request together: inrush limit.
        hold(450, 1'b0, 4'b1111, 4'b1111);
        hold(210, 1'b0, 4'b0000, 4'b0000);

        // Ungated requests are ignored.
        hold(20, 1'b0, 4'b1111, 4'b0000);

        // Ports 0 and 3 compete continuously.
        hold(900, 1'b0, 4'b1001, 4'b1001);
        hold(210, 1'b0, 4'b0000, 4'b0000);

        // Fill both slots, then port 2 pends and cancels.
        hold(3, 1'b0, 4'b0011, 4'b0011);
        hold(5, 1'b0, 4'b0100, 4'b0100);
        hold(210, 1'b0, 4'b0000, 4'b0000);

        // Reset in the middle of a wake-up, then a fresh full wake-up.
        hold(2, 1'b0, 4'b0001, 4'b0001);
        hold(101, 1'b0, 4'b0000, 4'b0001);
        hold(1, 1'b1, 4'b0000, 4'b0000);
        hold(2, 1'b0, 4'b0001, 4'b0001);
        hold(210, 1'b0, 4'b0000, 4'b0000);

        // Random traffic with occasional resets.
        rq = '0;
        pg = '0;
        for (int c = 0; c < 2500; c++) begin
            rq = rq ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            pg = pg ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            step(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, rq, pg);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pg_wakeup_scheduler

// File: doc/pg_wakeup_scheduler.md
PG_WAKEUP_SCHEDULER -- requirements
Module: pg_wakeup_scheduler

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of router power managers served.
REQ-002 Parameter MAX_ACTIVE, default 2: maximum ports allowed in wake-up at once (inrush limit).
REQ-003 Parameter WAKE_UP_LATENCY, default 200: cycles one wake-up occupies; legal range 1..255.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wake_req  input  NUM_PORTS  per-port level request to power a gated router back on.
REQ-007 pwr_gated  input  NUM_PORTS  per-port status, high while that router is power-gated.
REQ-008 wake_grant  output  NUM_PORTS  one-cycle pulse; the port may start its wake-up sequence.
REQ-009 waking  output  NUM_PORTS  high while the port holds a wake-up slot.
REQ-010 wake_done  output  NUM_PORTS  one-cycle pulse when the port's slot is released.
REQ-011 active_count  output  8  number of ports currently in WAKE.

Function
REQ-012 Each port SHALL run its own FSM with states IDLE, PEND, WAKE.
REQ-013 IDLE->PEND SHALL occur when wake_req and pwr_gated are both high for that port; wake_req without pwr_gated SHALL be ignored.
REQ-014 PEND->IDLE SHALL occur with no grant when wake_req falls or pwr_gated falls (cancel).
REQ-015 The arbiter SHALL issue at most one grant per cycle, only while active_count < MAX_ACTIVE, to a port in PEND whose request is still valid that cycle.
REQ-016 A grant SHALL pulse wake_grant for exactly one cycle and move the port PEND->WAKE on the same edge; waking SHALL assert the following cycle.
REQ-017 In WAKE, an 8-bit per-port counter SHALL count from 0. When it reaches WAKE_UP_LATENCY-1, the port SHALL return to IDLE, pulse wake_done, and free the slot, so waking is high for exactly WAKE_UP_LATENCY cycles.
REQ-018 wake_req and pwr_gated SHALL be ignored while a port is in WAKE; a port re-enters PEND only from IDLE.
REQ-019 A slot freed at an edge SHALL be grantable in the next cycle's arbitration, not the same cycle's. Release and grant in one cycle SHALL leave active_count unchanged.
REQ-020 active_count SHALL equal the population count of waking and SHALL never exceed MAX_ACTIVE.
REQ-021 With all slots busy, PEND ports SHALL wait indefinitely without loss of request.

Reset
REQ-022 On reset, all FSMs SHALL go to IDLE, counters to 0, arbiter pointer to port 0, and wake_grant, waking, wake_done and active_count to 0, including mid-wake-up.
REQ-023 The first grant after reset release SHALL occur no earlier than the second cycle after reset deasserts: one cycle to enter PEND, one to grant.

Configuration
REQ-024 With macro WAKE_RR_EN defined, arbitration SHALL be round-robin: the search starts at the port after the last granted port, wrapping from NUM_PORTS-1 to 0.
REQ-025 Without WAKE_RR_EN, arbitration SHALL be fixed priority, with the lowest port index winning. All other behaviour SHALL be identical.

Structure
REQ-026 Package pm_pkg SHALL hold the FSM state encoding (IDLE=2'b00, PEND=2'b01, WAKE=2'b10) and the counter width constant.
REQ-027 The arbiter SHALL be a sub-module wake_rr_arbiter (request vector, enable, one-hot grant, pointer update on grant); its round-robin/fixed selection SHALL be governed by WAKE_RR_EN.

Verification
REQ-028 Single request: port1 gated+req at cycle 0 -> wake_grant[1] pulse cycle 1, waking[1] high cycles 2..201, wake_done[1] pulse at release, active_count 1 then 0.
REQ-029 Inrush limit: all 4 ports request together, MAX_ACTIVE=2 -> grants to exactly 2 ports on consecutive cycles, remaining 2 granted only after wake_done; active_count never >2.
REQ-030 Fairness: WAKE_RR_EN, ports 0 and 3 re-request continuously -> grants alternate 0,3,0,3; without macro -> port 0 always wins when both pending.
REQ-031 Cancel: port2 enters PEND with slots full, drops wake_req -> returns IDLE, never granted, no wake_done.
REQ-032 Reset mid-wake: reset asserted at counter=100 -> next cycle all outputs 0; new request wakes for a full 200 cycles.
REQ-033 Ungated request: wake_req high, pwr_gated low -> no state change, no grant.
